// File: rtl/axi_mm_mem_responder.sv
// AXI4 slave memory model: 64-byte line RAM behind independent write and read FSMs.
// Every beat is one line, bursts are INCR by 64 B, DECERR on beats above the backed range.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, writing one line per W beat
// W_RESP  | bvalid high until bready
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | RAM read of the current line into the R payload register
// R_DATA  | rvalid high until rready
module axi_mm_mem_responder #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [11:0]               s_axi_awid,
    input  logic [63:0]               s_axi_awaddr,
    input  logic [9:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [11:0]               s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [11:0]               s_axi_arid,
    input  logic [63:0]               s_axi_araddr,
    input  logic [9:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [11:0]               s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);
    localparam int LINE_W = ADDR_WIDTH - 6;
    localparam int DEPTH  = 1 << LINE_W;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    wstate_t               r_wstate, w_wstate_nxt;
    rstate_t               r_rstate, w_rstate_nxt;
    logic                  r_live;
    logic [11:0]           r_awid;
    logic [63:0]           r_waddr;
    logic [9:0]            r_wlen, r_wcnt;
    logic                  r_werr;
    logic [11:0]           r_arid;
    logic [63:0]           r_raddr;
    logic [9:0]            r_rlen, r_rcnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic w_w_inrange, w_r_inrange, w_w_final;
    logic w_unused;

    assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_w_hs      = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
    assign w_r_hs      = s_axi_rvalid && s_axi_rready;
    assign w_w_inrange = (r_waddr[63:ADDR_WIDTH] == '0);
    assign w_r_inrange = (r_raddr[63:ADDR_WIDTH] == '0);
    assign w_w_final   = (r_wcnt == r_wlen);
    assign w_unused    = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst};

    // r_live holds the readies low while rst is asserted even though both FSMs sit in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_live   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_live   <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_rstate_nxt  = r_rstate;
        s_axi_awready = r_live && (r_wstate == W_IDLE);
        s_axi_wready  = (r_wstate == W_DATA);
        s_axi_bvalid  = (r_wstate == W_RESP);
        s_axi_bid     = r_awid;
        s_axi_bresp   = r_werr ? 2'b11 : 2'b00;
        s_axi_arready = r_live && (r_rstate == R_IDLE);
        s_axi_rvalid  = (r_rstate == R_DATA);
        s_axi_rid     = r_arid;
        s_axi_rdata   = r_rdata;
        s_axi_rresp   = r_rresp;
        s_axi_rlast   = r_rlast;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_w_final) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_FETCH;
            R_FETCH: w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs) w_rstate_nxt = r_rlast ? R_IDLE : R_FETCH;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awid  <= '0;
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_werr  <= 1'b0;
        end else if (w_aw_hs) begin
            r_awid  <= s_axi_awid;
            r_waddr <= s_axi_awaddr;
            r_wlen  <= s_axi_awlen;
            r_wcnt  <= '0;
            r_werr  <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= r_waddr + 64'd64;
            r_wcnt  <= r_wcnt + 10'd1;
            if (!w_w_inrange || (s_axi_wlast != w_w_final))
                r_werr <= 1'b1;
        end
    end

    // No reset on the array: contents survive rst
    always_ff @(posedge clk) begin
        if (w_w_hs && w_w_inrange && !rst) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b])
                    r_mem[r_waddr[ADDR_WIDTH-1:6]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arid  <= '0;
            r_raddr <= '0;
            r_rlen  <= '0;
            r_rcnt  <= '0;
            r_rdata <= '0;
            r_rresp <= 2'b00;
            r_rlast <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_arid  <= s_axi_arid;
                r_raddr <= s_axi_araddr;
                r_rlen  <= s_axi_arlen;
                r_rcnt  <= '0;
            end
            if (r_rstate == R_FETCH) begin
                r_rdata <= w_r_inrange ? r_mem[r_raddr[ADDR_WIDTH-1:6]] : '0;
                r_rresp <= w_r_inrange ? 2'b00 : 2'b11;
                r_rlast <= (r_rcnt == r_rlen);
            end
            if (w_r_hs && !r_rlast) begin
                r_raddr <= r_raddr + 64'd64;
                r_rcnt  <= r_rcnt + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_mm_mem_responder.sv
// Directed bench for axi_mm_mem_responder: tasks drive AW/W/AR, expected B and R
// responses go into queues that two monitors compare against the bus.
module tb_axi_mm_mem_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  s_axi_awid;
    logic [63:0]  s_axi_awaddr;
    logic [9:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [511:0] s_axi_wdata;
    logic [63:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [11:0]  s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [11:0]  s_axi_arid;
    logic [63:0]  s_axi_araddr;
    logic [9:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [11:0]  s_axi_rid;
    logic [511:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;

    always #5 clk = ~clk;

    axi_mm_mem_responder #(.ADDR_WIDTH(20), .DATA_WIDTH(512)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct { logic [11:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [11:0] id; logic [511:0] data; logic [1:0] resp; logic last; } r_t;
    b_t bq[$];
    r_t rq[$];
    int n_cmp = 0;
    int n_err = 0;
    bit rr_toggle = 1'b0;

    logic [511:0] pat_a;
    logic [511:0] pat_b;

    function automatic logic [511:0] mkd(input logic [31:0] k);
        return {16{k}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_r(input logic [11:0] id, input logic [511:0] data,
                         input logic [1:0] resp, input logic last);
        rq.push_back('{id, data, resp, last});
    endtask

    // Waits on negedges for the selected condition; expiry counts as a failed comparison
    task automatic wait_hi(input int sel, input string name, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            cyc = c;
            case (sel)
                0:       hit = s_axi_awready;
                1:       hit = s_axi_wready;
                2:       hit = s_axi_arready;
                3:       hit = s_axi_bvalid && s_axi_bready;
                default: hit = s_axi_rvalid && s_axi_rready && s_axi_rlast;
            endcase
            if (hit) break;
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: no handshake seen, expected one within 300 cycles", name);
        end
    endtask

    task automatic wr(input logic [11:0] id, input logic [63:0] addr, input int len,
                      input logic [31:0] base, input logic [63:0] strb, input bit early,
                      input logic [1:0] resp);
        int cyc;
        bq.push_back('{id, resp});
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len[9:0]; s_axi_awvalid = 1'b1;
        wait_hi(0, "aw", cyc);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata  = mkd(base + 32'(i));
            s_axi_wstrb  = strb;
            s_axi_wlast  = early ? (i == 0) : (i == len);
            s_axi_wvalid = 1'b1;
            wait_hi(1, "w", cyc);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        wait_hi(3, "b", cyc);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [11:0] id, input logic [63:0] addr, input int len, input bit lat);
        int cyc;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len[9:0]; s_axi_arvalid = 1'b1;
        wait_hi(2, "ar", cyc);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        if (lat) begin
            @(negedge clk);
            chk("rvalid_t1", 512'(s_axi_rvalid), 512'd0);
            wait_hi(4, "r", cyc);
            chk("rvalid_t2_latency", 512'(cyc), 512'd1);
        end else begin
            wait_hi(4, "r", cyc);
        end
        @(posedge clk); #1;
    endtask

    // B monitor: compares head of queue on every valid cycle, pops on handshake
    initial forever begin
        @(negedge clk);
        if (!rst && s_axi_bvalid) begin
            if (bq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected: got bvalid id=%0d, expected no response", s_axi_bid);
            end else begin
                chk("bid", 512'(s_axi_bid), 512'(bq[0].id));
                chk("bresp", 512'(s_axi_bresp), 512'(bq[0].resp));
                if (s_axi_bready) void'(bq.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && s_axi_rvalid) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL r_unexpected: got rvalid id=%0d, expected no beat", s_axi_rid);
            end else begin
                chk("rid", 512'(s_axi_rid), 512'(rq[0].id));
                chk("rdata", s_axi_rdata, rq[0].data);
                chk("rresp", 512'(s_axi_rresp), 512'(rq[0].resp));
                chk("rlast", 512'(s_axi_rlast), 512'(rq[0].last));
                if (s_axi_rready) void'(rq.pop_front());
            end
        end
    end

    initial begin
        s_axi_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            s_axi_rready = rr_toggle ? ~s_axi_rready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        pat_a = mkd(32'hAAAA_0001);
        pat_b = mkd(32'hBBBB_0002);
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd6;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd6;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 512'(s_axi_awready), 512'd0);
        chk("rst_wready", 512'(s_axi_wready), 512'd0);
        chk("rst_bvalid", 512'(s_axi_bvalid), 512'd0);
        chk("rst_arready", 512'(s_axi_arready), 512'd0);
        chk("rst_rvalid", 512'(s_axi_rvalid), 512'd0);
        chk("rst_rlast", 512'(s_axi_rlast), 512'd0);
        chk("rst_bid_bresp", 512'({s_axi_bid, s_axi_bresp}), 512'd0);
        chk("rst_rid_rresp", 512'({s_axi_rid, s_axi_rresp}), 512'd0);
        chk("rst_rdata", s_axi_rdata, 512'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("awready_after_rst", 512'(s_axi_awready), 512'd1);
        chk("arready_after_rst", 512'(s_axi_arready), 512'd1);
        @(posedge clk); #1;

        // Single write then read, with read latency check
        wr(12'd5, 64'h40, 0, 32'hAAAA_0001, '1, 1'b0, 2'b00);
        exp_r(12'd7, pat_a, 2'b00, 1'b1);
        rd(12'd7, 64'h40, 0, 1'b1);

        // Partial strobe over existing A, with B back-pressure
        wr(12'd1, 64'h80, 0, 32'hAAAA_0001, '1, 1'b0, 2'b00);
        s_axi_bready = 1'b0;
        fork
            begin repeat (6) @(posedge clk); #1; s_axi_bready = 1'b1; end
        join_none
        wr(12'd2, 64'h80, 0, 32'hBBBB_0002, 64'h0000_0000_0000_00FF, 1'b0, 2'b00);
        exp_r(12'd3, {pat_a[511:64], pat_b[63:0]}, 2'b00, 1'b1);
        rd(12'd3, 64'h80, 0, 1'b0);

        // 4-beat burst, read back with rready toggling
        wr(12'd8, 64'h1000, 3, 32'h1000_0000, '1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) exp_r(12'd9, mkd(32'h1000_0000 + 32'(i)), 2'b00, i == 3);
        rr_toggle = 1'b1;
        rd(12'd9, 64'h1000, 3, 1'b0);
        rr_toggle = 1'b0;

        // Burst crossing the top of memory: first beat written, DECERR
        wr(12'd10, 64'hF_FFC0, 1, 32'hE000_0000, '1, 1'b0, 2'b11);
        exp_r(12'd11, mkd(32'hE000_0000), 2'b00, 1'b0);
        exp_r(12'd11, 512'd0, 2'b11, 1'b1);
        rd(12'd11, 64'hF_FFC0, 1, 1'b0);

        // Early wlast: both beats still consumed and written
        wr(12'd12, 64'h200, 1, 32'hC000_0000, '1, 1'b1, 2'b11);
        exp_r(12'd13, mkd(32'hC000_0001), 2'b00, 1'b1);
        rd(12'd13, 64'h240, 0, 1'b0);

        exp_r(12'd14, 512'd0, 2'b11, 1'b1);
        rd(12'd14, 64'h10_0000, 0, 1'b0);

        // Concurrent write and read bursts on different lines
        for (int i = 0; i < 4; i++) exp_r(12'd16, mkd(32'h1000_0000 + 32'(i)), 2'b00, i == 3);
        fork
            wr(12'd17, 64'h2000, 3, 32'h2000_0000, '1, 1'b0, 2'b00);
            rd(12'd16, 64'h1000, 3, 1'b0);
        join
        for (int i = 0; i < 4; i++) exp_r(12'd18, mkd(32'h2000_0000 + 32'(i)), 2'b00, i == 3);
        rd(12'd18, 64'h2000, 3, 1'b0);

        // Same-cycle read fetch and write beat on one line: old data returned
        exp_r(12'd19, pat_a, 2'b00, 1'b1);
        fork
            wr(12'd20, 64'h40, 0, 32'hD000_0000, '1, 1'b0, 2'b00);
            rd(12'd19, 64'h40, 0, 1'b0);
        join
        exp_r(12'd21, mkd(32'hD000_0000), 2'b00, 1'b1);
        rd(12'd21, 64'h40, 0, 1'b0);

        // Reset during beat 2 of a len=7 write
        s_axi_awid = 12'd22; s_axi_awaddr = 64'h3000; s_axi_awlen = 10'd7; s_axi_awvalid = 1'b1;
        wait_hi(0, "aw_rst", cyc);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_axi_wdata = mkd(32'h3000_0000 + 32'(i));
            s_axi_wstrb = '1;
            s_axi_wlast = 1'b0;
            s_axi_wvalid = 1'b1;
            if (i == 2) rst = 1'b1;
            wait_hi(1, "w_rst", cyc);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("bvalid_after_abort", 512'(s_axi_bvalid), 512'd0);
        @(posedge clk);
        @(negedge clk);
        chk("awready_after_abort", 512'(s_axi_awready), 512'd1);
        chk("bvalid_after_abort2", 512'(s_axi_bvalid), 512'd0);
        @(posedge clk); #1;
        wr(12'd23, 64'h3000, 0, 32'h3100_0000, '1, 1'b0, 2'b00);
        exp_r(12'd24, mkd(32'h3000_0001), 2'b00, 1'b1);
        rd(12'd24, 64'h3040, 0, 1'b0);
        exp_r(12'd25, mkd(32'h3100_0000), 2'b00, 1'b1);
        rd(12'd25, 64'h3000, 0, 1'b0);

        repeat (4) @(posedge clk);
        chk("b_queue_drained", 512'(bq.size()), 512'd0);
        chk("r_queue_drained", 512'(rq.size()), 512'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
